// File: rtl/rom_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words from a
// length-prefixed byte stream and writes them to instruction memory from
// address 0, holding the CPU in reset while a session is in progress.
// Optional trailing XOR checksum byte: define ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [7:0]  len_hi_q;
  logic [15:0] word_count;
  logic [7:0]  hi_byte;
  logic        accept;
  logic        start_ok;
  logic [15:0] len_rx;
  logic        len_oversize;
  logic        more_words;
  state_t      end_state;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_acc;
  assign end_state = S_CHK;
`else
  assign end_state = S_DONE;
`endif

  assign accept       = rx_valid && rx_ready;
  assign start_ok     = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign len_rx       = {len_hi_q, rx_data};
  assign len_oversize = {1'b0, len_rx} > MAX_LEN;
  // The write in progress is word words_loaded+1; more follow if that is still short of N.
  assign more_words   = ({1'b0, words_loaded} + 17'd1) < {1'b0, word_count};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output and next-state gets a default first, so no path
  // through the case can leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    wr_en      = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_rx == 16'd0)   state_next = end_state;
          else if (len_oversize) state_next = S_ERROR;
          else                   state_next = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        wr_en      = 1'b1;
        state_next = more_words ? S_DATA_HI : end_state;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CHK: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = (rx_data == chk_acc) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      S_ERROR: begin
        cpu_hold = 1'b0;
        error    = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      default: begin
        cpu_hold   = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: length capture, word assembly, write address/data and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_hi_q     <= 8'h00;
      word_count   <= 16'h0000;
      hi_byte      <= 8'h00;
      wr_addr      <= '0;
      wr_data      <= 16'h0000;
      words_loaded <= 16'h0000;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_acc      <= 8'h00;
`endif
    end else begin
      if (start_ok) begin
        words_loaded <= 16'h0000;
`ifdef ROM_LOADER_CHECKSUM_EN
        chk_acc      <= 8'h00;
`endif
      end
      case (state)
        S_LEN_HI:  if (accept) len_hi_q   <= rx_data;
        S_LEN_LO:  if (accept) word_count <= len_rx;
        S_DATA_HI: if (accept) begin
          hi_byte <= rx_data;
`ifdef ROM_LOADER_CHECKSUM_EN
          chk_acc <= chk_acc ^ rx_data;
`endif
        end
        S_DATA_LO: if (accept) begin
          // Address and data are loaded here so they are stable for the whole WRITE cycle.
          wr_data <= {hi_byte, rx_data};
          wr_addr <= ADDR_W'(words_loaded);
`ifdef ROM_LOADER_CHECKSUM_EN
          chk_acc <= chk_acc ^ rx_data;
`endif
        end
        S_WRITE:   words_loaded <= words_loaded + 16'd1;
        default:   ;
      endcase
    end
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Byte-stream program loader that writes the 32K x 16 instruction memory at run time. It accepts a length-prefixed stream of bytes from a UART receiver or a test source and assembles big-endian 16-bit instruction words. It writes those words to consecutive instruction-memory addresses starting at 0, and holds the CPU in reset until the image is complete. It sits between the serial receive path and the instruction memory's write port, alongside the CPU's fetch port.

## Interface

- `ADDR_W`, default 15: instruction-memory address width.
- `MAX_WORDS`, default 32768: largest accepted word count. A larger count is an error.

- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high. Forces every register and output to its reset value immediately.
- `start` in 1: single-cycle request to begin a load session. Honoured only in IDLE, DONE or ERROR.
- `rx_data` in 8: incoming stream byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader can accept a byte. A byte transfers on a rising edge where `rx_valid && rx_ready`.
- `wr_en` out 1: single-cycle write strobe to the instruction memory.
- `wr_addr` out `ADDR_W`: write address.
- `wr_data` out 16: write data.
- `cpu_hold` out 1: keep the CPU in reset. High whenever a session is in progress.
- `done` out 1: level; the image loaded successfully.
- `error` out 1: level; the session aborted.
- `words_loaded` out 16: number of words written in the current or last session.

## Operation

- Stream format, in order:
  - LEN_HI, LEN_LO: word count N, 16 bits, big-endian.
  - N words, each sent as HI byte then LO byte.
  - Optional checksum byte (see Configuration).
- States and transitions:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on byte accept.
  - LEN_LO → DATA_HI on byte accept if 0 < N <= MAX_WORDS.
  - LEN_LO → DONE if N = 0 (→ CHK when checksum is enabled).
  - LEN_LO → ERROR if N > MAX_WORDS.
  - DATA_HI → DATA_LO on byte accept.
  - DATA_LO → WRITE on byte accept.
  - WRITE → DATA_HI if words written < N, otherwise → DONE (or CHK).
  - DONE and ERROR → LEN_HI on `start`.
- `rx_ready` = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK. It is 0 in IDLE, WRITE, DONE and ERROR.
- In WRITE:
  - `wr_en` = 1 for exactly one cycle.
  - `wr_data` = {HI, LO}.
  - `wr_addr` = word index, starting at 0 and incrementing by 1.
  - `words_loaded` increments in the same cycle.
  - `wr_addr` never wraps, because N <= MAX_WORDS.
- `start` resets the word index, `words_loaded`, `done`, `error` and the checksum accumulator.
- `start` is ignored while in LEN_HI through CHK.
- `cpu_hold` = 1 in every state except IDLE, DONE and ERROR.
- `wr_addr` and `wr_data` hold their last values outside WRITE.

## Timing

- Reset values:
  - state IDLE.
  - `rx_ready`, `wr_en`, `cpu_hold`, `done`, `error` all 0.
  - `wr_addr`, `wr_data`, `words_loaded` all 0.
- `start` sampled high in cycle t: `cpu_hold` and `rx_ready` are 1 from cycle t+1.
- Per-word cost: at least 3 cycles (HI, LO, WRITE).
- Session length with `rx_valid` held high: 2 + 3N cycles + 1 cycle into DONE (+1 with checksum).
- The LO byte accepted at edge e: `wr_en` is high in the cycle after e.
- After the final write: `done` = 1 and `cpu_hold` = 0 in the next cycle.
- Backpressure: gaps in `rx_valid` stall the state; no byte is duplicated or dropped.
- `reset` mid-session: aborts immediately and all outputs go to reset values. Words already written stay in memory. The next `start` reloads from address 0.

## Configuration

- `ROM_LOADER_CHECKSUM_EN` defined:
  - After the last word (or after LEN_LO when N = 0), state CHK accepts one byte.
  - The byte is compared with the XOR of all 2N data bytes; length bytes are excluded, and the accumulator starts at 0x00.
  - Match → DONE. Mismatch → ERROR, with `words_loaded` still reporting N.
- Undefined: the CHK state and the accumulator are absent, and the last WRITE (or N = 0) goes straight to DONE.

## Test plan

- Basic load: stream 00 02 00 03 EC 10 with `rx_valid` held high → `wr_en` pulses at (addr 0, 0x0003) and (addr 1, 0xEC10). Then `done` = 1, `words_loaded` = 2, `cpu_hold` = 0 after 9 cycles (10 with the checksum byte 0xFF appended).
- Backpressure: same stream with `rx_valid` high every third cycle → identical writes, exactly 2 `wr_en` pulses, `rx_ready` never high in WRITE.
- Zero length: stream 00 00 → `done` = 1, no `wr_en`. With the macro enabled, the checksum byte 00 is also required.
- Oversize: stream 80 01 → `error` = 1 the cycle after LEN_LO, no `wr_en`, `rx_ready` = 0. A subsequent `start` returns to LEN_HI.
- Reset mid-stream: assert `reset` after the first word is written → all outputs 0 immediately. Then a fresh `start` and 1-word stream 00 01 12 34 → write at addr 0, data 0x1234.
- Checksum error (macro on): stream 00 01 AB CD 00 → `error` = 1, `done` = 0, `words_loaded` = 1. With checksum byte 66 instead → `done` = 1.
